// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray outputs.
// Wraps or saturates at the range ends; loads binary or Gray values.
module gray_updown_counter #(
    parameter int          WIDTH   = 6,
    parameter int          WRAP    = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_binary,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RST_B = RST_VAL[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] from_gray(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_d;
    logic             wrap_d;

    always_comb begin
        bin_d  = out_binary;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_gray ? from_gray(load_value) : load_value;
        end else if (en) begin
            if (up) begin
                if (out_binary != MAX) begin
                    bin_d = out_binary + ONE;
                end else if (WRAP != 0) begin
                    bin_d  = ZERO;
                    wrap_d = 1'b1;
                end
            end else begin
                if (out_binary != ZERO) begin
                    bin_d = out_binary - ONE;
                end else if (WRAP != 0) begin
                    bin_d  = MAX;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Gray output is registered from the next binary value, so both
    // outputs change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_binary <= RST_B;
            out_gray   <= to_gray(RST_B);
            wrap_pulse <= 1'b0;
        end else begin
            out_binary <= bin_d;
            out_gray   <= to_gray(bin_d);
            wrap_pulse <= wrap_d;
        end
    end

    assign at_max = (out_binary == MAX);
    assign at_min = (out_binary == ZERO);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: several parameter sets
// driven in parallel, checked by vectors, sequences and a random model.
module tb_gray_updown_counter;

    localparam int N = 6;
    localparam int          WS [N] = '{4, 4, 4, 2, 6, 16};
    localparam int          WR [N] = '{1, 0, 1, 1, 0, 1};
    localparam int unsigned RV [N] = '{0, 0, 5, 0, 0, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic        lg = 1'b0;
    logic [15:0] lv = '0;

    logic [31:0] ob [N];
    logic [31:0] og [N];
    logic        wp [N];
    logic        amx [N];
    logic        amn [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        logic [WS[k]-1:0] b;
        logic [WS[k]-1:0] g;
        logic             p;
        logic             mx;
        logic             mn;
        gray_updown_counter #(
            .WIDTH  (WS[k]),
            .WRAP   (WR[k]),
            .RST_VAL(RV[k])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .up        (up),
            .load      (load),
            .load_gray (lg),
            .load_value(lv[WS[k]-1:0]),
            .out_gray  (g),
            .out_binary(b),
            .wrap_pulse(p),
            .at_max    (mx),
            .at_min    (mn)
        );
        assign ob[k]  = 32'(b);
        assign og[k]  = 32'(g);
        assign wp[k]  = p;
        assign amx[k] = mx;
        assign amn[k] = mn;
    end

    int checks = 0;
    int errors = 0;

    longint mb [N];
    bit     mp [N];
    logic [31:0] pg [N];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint gdec(longint g);
        longint b = 0;
        for (longint s = g; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    task automatic model_step(int k);
        longint mx = (longint'(1) << WS[k]) - 1;
        mp[k] = 1'b0;
        if (rst) begin
            mb[k] = longint'(RV[k]);
        end else if (load) begin
            mb[k] = lg ? gdec(longint'(lv) & mx) : (longint'(lv) & mx);
        end else if (en) begin
            if (up) begin
                if (mb[k] < mx) mb[k] = mb[k] + 1;
                else if (WR[k] != 0) begin
                    mb[k] = 0;
                    mp[k] = 1'b1;
                end
            end else begin
                if (mb[k] > 0) mb[k] = mb[k] - 1;
                else if (WR[k] != 0) begin
                    mb[k] = mx;
                    mp[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        longint prev [N];
        bit     cnt;
        cnt = 1'b0;
        for (int k = 0; k < N; k++) pg[k] = og[k];
        @(posedge clk);
        cnt = !rst && !load && en;
        for (int k = 0; k < N; k++) begin
            prev[k] = mb[k];
            model_step(k);
        end
        #1;
        for (int k = 0; k < N; k++) begin
            longint mx = (longint'(1) << WS[k]) - 1;
            chk($sformatf("bin[%0d]", k), 64'(ob[k]), 64'(mb[k]));
            chk($sformatf("gray[%0d]", k), 64'(og[k]),
                64'(mb[k] ^ (mb[k] >> 1)));
            chk($sformatf("grayrel[%0d]", k), 64'(og[k]),
                64'(ob[k] ^ (ob[k] >> 1)));
            chk($sformatf("pulse[%0d]", k), 64'(wp[k]), 64'(mp[k]));
            chk($sformatf("atmax[%0d]", k), 64'(amx[k]), 64'(mb[k] == mx));
            chk($sformatf("atmin[%0d]", k), 64'(amn[k]), 64'(mb[k] == 0));
            if (cnt && mb[k] != prev[k])
                chk($sformatf("onebit[%0d]", k),
                    64'($countones(og[k] ^ pg[k])), 64'd1);
        end
    endtask

    task automatic drive(bit r, bit e, bit u, bit l, bit g, logic [15:0] v);
        rst = r; en = e; up = u; load = l; lg = g; lv = v;
    endtask

    typedef struct {
        bit       r, e, u, l, g;
        logic [3:0] v;
        logic [3:0] eb, eg;
        bit       ep, emx, emn;
    } vec_t;

    initial begin
        vec_t vt [13];
        logic [3:0] gseq [16];
        gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        for (int k = 0; k < N; k++) begin
            mb[k] = 0;
            mp[k] = 1'b0;
        end

        // Instance 0: WIDTH=4, wrapping, reset value 0.
        vt[0]  = '{1, 1, 1, 1, 0, 4'h9, 4'h0, 4'h0, 0, 0, 1};
        vt[1]  = '{0, 1, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h3, 0, 0, 0};
        vt[3]  = '{0, 1, 1, 1, 1, 4'hD, 4'h9, 4'hD, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 1, 0, 4'h9, 4'h9, 4'hD, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1};
        vt[6]  = '{0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h8, 1, 1, 0};
        vt[7]  = '{0, 0, 0, 0, 0, 4'h0, 4'hF, 4'h8, 0, 1, 0};
        vt[8]  = '{0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 1};
        vt[9]  = '{0, 1, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 0, 0};
        vt[10] = '{0, 0, 0, 1, 0, 4'hF, 4'hF, 4'h8, 0, 1, 0};
        vt[11] = '{1, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1};
        vt[12] = '{0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h8, 1, 1, 0};

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].r, vt[i].e, vt[i].u, vt[i].l, vt[i].g, 16'(vt[i].v));
            cycle();
            chk($sformatf("vec%0d bin", i), 64'(ob[0]), 64'(vt[i].eb));
            chk($sformatf("vec%0d gray", i), 64'(og[0]), 64'(vt[i].eg));
            chk($sformatf("vec%0d pulse", i), 64'(wp[0]), 64'(vt[i].ep));
            chk($sformatf("vec%0d atmax", i), 64'(amx[0]), 64'(vt[i].emx));
            chk($sformatf("vec%0d atmin", i), 64'(amn[0]), 64'(vt[i].emn));
        end

        // Full up-count with wrap on the 4-bit instance.
        drive(1, 0, 0, 0, 0, 16'h0);
        cycle();
        drive(0, 1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk($sformatf("seq gray%0d", i), 64'(og[0]), 64'(gseq[i]));
            chk($sformatf("seq pulse%0d", i), 64'(wp[0]), 64'(i == 15));
        end

        // Saturation on the non-wrapping 4-bit instance.
        drive(0, 0, 0, 1, 0, 16'hF);
        cycle();
        drive(0, 1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sat bin", 64'(ob[1]), 64'hF);
            chk("sat pulse", 64'(wp[1]), 64'h0);
        end
        up = 1'b0;
        cycle();
        chk("sat down bin", 64'(ob[1]), 64'hE);
        chk("sat down gray", 64'(og[1]), 64'h9);

        // Reset dominates load and enable; RST_VAL=5 instance.
        drive(1, 1, 1, 1, 0, 16'hA);
        cycle();
        chk("rst5 bin", 64'(ob[2]), 64'h5);
        chk("rst5 gray", 64'(og[2]), 64'h7);
        chk("rst5 pulse", 64'(wp[2]), 64'h0);
        drive(0, 1, 1, 0, 0, 16'h0);
        cycle();
        chk("post rst step", 64'(ob[2]), 64'h6);

        // Reset coincident with a wrap suppresses the pulse.
        drive(0, 0, 0, 1, 0, 16'hF);
        cycle();
        drive(1, 1, 1, 0, 0, 16'h0);
        cycle();
        chk("rst wrap pulse", 64'(wp[0]), 64'h0);

        // Back-to-back wraps on the 2-bit instance.
        drive(0, 1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("w2 pulse%0d", i), 64'(wp[3]), 64'(i % 4 == 3));
        end

        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(9) < 7,
                  1'($urandom), $urandom_range(9) == 0,
                  1'($urandom), 16'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 6, meaning counter width in bits; legal range 2..32.
REQ-002 The block SHALL provide parameter WRAP, default 1, meaning 1 = wrap-around at the ends of the range, 0 = saturate at the ends.
REQ-003 The block SHALL provide parameter RST_VAL, default 0, meaning the binary count value loaded by reset, range 0..2^WIDTH-1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  count enable; one step per cycle while high.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when a count step occurs.
REQ-009 load  input  1  synchronous load of load_value.
REQ-010 load_gray  input  1  1 = load_value is Gray-coded, 0 = load_value is plain binary.
REQ-011 load_value  input  WIDTH  value to load.
REQ-012 out_gray  output  WIDTH  registered Gray code of the current count.
REQ-013 out_binary  output  WIDTH  registered binary value of the current count.
REQ-014 wrap_pulse  output  1  registered one-cycle pulse marking a wrap-around step.
REQ-015 at_max  output  1  high while out_binary = 2^WIDTH-1.
REQ-016 at_min  output  1  high while out_binary = 0.

Function
REQ-017 Per-edge priority SHALL be rst > load > en; with all three low, the state SHALL hold.
REQ-018 out_gray and out_binary SHALL both be driven from flops, with out_gray = out_binary XOR (out_binary >> 1) in every cycle.
REQ-019 A count step (en=1, load=0, rst=0) SHALL update both outputs on the same edge: latency 1 cycle, and no combinational path from inputs to outputs.
REQ-020 Load with load_gray=0 SHALL set out_binary = load_value on the next edge.
REQ-021 Load with load_gray=1 SHALL set out_binary to the Gray decode of load_value: b[W-1] = g[W-1], and b[i] = g[i] XOR b[i+1] for i from W-2 down to 0.
REQ-022 Load SHALL override en in the same cycle, and load SHALL never assert wrap_pulse.
REQ-023 Every count step that changes the count SHALL change exactly one bit of out_gray.
REQ-024 With WRAP=1, an up step at 2^WIDTH-1 SHALL go to 0, and a down step at 0 SHALL go to 2^WIDTH-1.
REQ-025 With WRAP=1, wrap_pulse SHALL be high for exactly the cycle following a wrapping edge, and low otherwise.
REQ-026 With WRAP=0, an up step at 2^WIDTH-1 or a down step at 0 SHALL hold the value, leave out_gray unchanged, and keep wrap_pulse low.
REQ-027 Stepping away from an end (e.g. down at max, up at min) SHALL be a normal step with no pulse.
REQ-028 at_max and at_min SHALL be decoded from the output registers only, with no dependence on en, up or load.
REQ-029 Back-to-back wraps (WIDTH=2, continuous stepping) SHALL produce one pulse per wrap, with wrap_pulse low in between.

Reset
REQ-030 On rst=1 at an edge, out_binary SHALL be RST_VAL, out_gray SHALL be the Gray code of RST_VAL, and wrap_pulse SHALL be 0, regardless of en and load.
REQ-031 Reset asserted mid-count or coincident with a wrap SHALL suppress the pulse.
REQ-032 The cycle after rst deasserts SHALL act normally on en and load.
REQ-033 at_max and at_min SHALL reflect RST_VAL immediately after the reset edge.

Verification (WIDTH=4 unless stated)
REQ-034 Reset then en=1, up=1 for 16 cycles -> out_gray steps 0000,0001,0011,0010,0110,...,1000, then 0000; wrap_pulse high only in the cycle out_gray returns to 0000; single-bit Gray change on every step.
REQ-035 load=1, load_gray=1, load_value=1101 -> next cycle out_binary=1001, out_gray=1101; load=1, load_gray=0, load_value=1001 -> identical result.
REQ-036 WRAP=1, count at 0, en=1, up=0 -> out_binary=1111, out_gray=1000, wrap_pulse=1 for one cycle, at_max=1.
REQ-037 WRAP=0, count at 1111, en=1, up=1 for 3 cycles -> out_binary stays 1111, wrap_pulse stays 0; then up=0 -> 1110, out_gray=1001.
REQ-038 rst=1 with load=1, en=1, RST_VAL=5 -> out_binary=0101, out_gray=0111, wrap_pulse=0; load together with en -> load value wins.
REQ-039 Random en/up/load for 10k cycles, WIDTH in {2,6,16} -> scoreboard match on out_binary, the Gray relation of REQ-018 holds every cycle, and the flags and pulse match the model.
